// File: rtl/tiny_fir_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tiny_fir_ctrl_pkg
// Shared types for the FIR reload controller: the controller state encoding
// and small decode helpers so the top and any checker agree on what "busy"
// and "FIR enabled" mean for each state.
// -----------------------------------------------------------------------------
package tiny_fir_ctrl_pkg;

  typedef enum logic [2:0] {
    S_UNLOADED   = 3'd0,
    S_DRAIN      = 3'd1,
    S_DISABLE    = 3'd2,
    S_WAIT_READY = 3'd3,
    S_LOAD       = 3'd4,
    S_WAIT_DONE  = 3'd5,
    S_RUN        = 3'd6
  } state_t;

  // The reload sequence spans DRAIN through WAIT_DONE.
  function automatic logic state_is_busy(input state_t s);
    return (s == S_DRAIN) || (s == S_DISABLE) || (s == S_WAIT_READY) ||
           (s == S_LOAD)  || (s == S_WAIT_DONE);
  endfunction

  // The FIR is held in reset only while unloaded and for the single
  // DISABLE cycle that flushes it before new taps are streamed in.
  function automatic logic state_fir_enabled(input state_t s);
    return !((s == S_UNLOADED) || (s == S_DISABLE));
  endfunction

endpackage

// File: rtl/tiny_fir_ctrl_coef_bank.sv
// -----------------------------------------------------------------------------
// tiny_fir_ctrl_coef_bank
// Shadow coefficient register array. One synchronous write port, one
// asynchronous read port. Contents are deliberately not reset: software
// programs the bank before requesting a reload, and a reset must not lose it.
//
// Ports
//   i_clk       clock
//   i_wr_en     write strobe (already qualified by the caller)
//   i_wr_addr   write index
//   i_wr_data   write value
//   i_rd_addr   read index
//   o_rd_data   combinational read value
// -----------------------------------------------------------------------------
module tiny_fir_ctrl_coef_bank #(
  parameter int G_NUM_TAPS  = 16,
  parameter int G_TAP_WIDTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_wr_en,
  input  logic [$clog2(G_NUM_TAPS)-1:0] i_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]        i_wr_data,
  input  logic [$clog2(G_NUM_TAPS)-1:0] i_rd_addr,
  output logic [G_TAP_WIDTH-1:0]        o_rd_data
);

  logic [G_TAP_WIDTH-1:0] r_bank [G_NUM_TAPS];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_bank[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_bank[i_rd_addr];

endmodule

// File: rtl/tiny_fir_ctrl.sv
// -----------------------------------------------------------------------------
// tiny_fir_ctrl
// Reload controller sitting between a user sample stream and an external FIR.
// Software writes coefficients into a shadow bank, then pulses cfg_apply. The
// controller stops accepting input, waits for every accepted sample to come
// back out, pulses the FIR reset for one cycle, streams all shadow taps into
// the FIR, waits for the FIR to report completion and resumes streaming.
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   cfg_wr_addr/data/en               shadow bank write port (ignored while busy)
//   cfg_apply                         reload request pulse (UNLOADED/RUN only)
//   cfg_busy, cfg_loaded              reload in progress / FIR holds valid taps
//   s_din*                            user input stream  -> gated into fir_din*
//   fir_din*                          FIR input stream
//   fir_dout*                         FIR output stream  -> passed to m_dout*
//   m_dout*                           user output stream
//   fir_enable                        FIR enable, low level resets the FIR
//   fir_tap_din*, fir_tap_din_done    tap programming stream and completion
//   dbg_state                         current controller state
//
// Handshakes: every stream uses valid/ready; a transfer happens on a rising
// clk edge where valid and ready are both 1. A source holds data stable while
// valid=1 and ready=0; valid never depends on ready.
// -----------------------------------------------------------------------------
module tiny_fir_ctrl
  import tiny_fir_ctrl_pkg::*;
#(
  parameter int G_NUM_TAPS   = 16,
  parameter int G_DATA_WIDTH = 16,
  parameter int G_TAP_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [$clog2(G_NUM_TAPS)-1:0] cfg_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]        cfg_wr_data,
  input  logic                          cfg_wr_en,
  input  logic                          cfg_apply,
  output logic                          cfg_busy,
  output logic                          cfg_loaded,
  input  logic [G_DATA_WIDTH-1:0]       s_din,
  input  logic                          s_din_valid,
  output logic                          s_din_ready,
  output logic [G_DATA_WIDTH-1:0]       fir_din,
  output logic                          fir_din_valid,
  input  logic                          fir_din_ready,
  input  logic [G_DATA_WIDTH-1:0]       fir_dout,
  input  logic                          fir_dout_valid,
  output logic                          fir_dout_ready,
  output logic [G_DATA_WIDTH-1:0]       m_dout,
  output logic                          m_dout_valid,
  input  logic                          m_dout_ready,
  output logic                          fir_enable,
  output logic [G_TAP_WIDTH-1:0]        fir_tap_din,
  output logic                          fir_tap_din_valid,
  input  logic                          fir_tap_din_ready,
  input  logic                          fir_tap_din_done,
  output state_t                        dbg_state
);

  localparam int              AW          = $clog2(G_NUM_TAPS);
  localparam logic [AW-1:0]   LP_LAST_TAP = AW'(G_NUM_TAPS - 1);

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_tap_idx;
  logic [1:0]      r_inflight;
  logic            r_loaded;

  logic            w_run;
  logic            w_in_hs;
  logic            w_out_hs;
  logic            w_tap_hs;
  logic            w_fir_enable;
  logic            w_busy;
  logic            w_tap_valid;
  logic            w_shadow_we;
  logic [G_TAP_WIDTH-1:0] w_tap_data;

  // ---------------------------------------------------------------------------
  // Shadow bank
  // ---------------------------------------------------------------------------
  assign w_shadow_we = cfg_wr_en & ~w_busy;

  tiny_fir_ctrl_coef_bank #(
    .G_NUM_TAPS  (G_NUM_TAPS),
    .G_TAP_WIDTH (G_TAP_WIDTH)
  ) u_coef_bank (
    .i_clk     (clk),
    .i_wr_en   (w_shadow_we),
    .i_wr_addr (cfg_wr_addr),
    .i_wr_data (cfg_wr_data),
    .i_rd_addr (r_tap_idx),
    .o_rd_data (w_tap_data)
  );

  // ---------------------------------------------------------------------------
  // Data paths
  // ---------------------------------------------------------------------------
  assign w_run          = (r_state == S_RUN);
  assign fir_din        = s_din;
  assign fir_din_valid  = s_din_valid & w_run;
  assign s_din_ready    = fir_din_ready & w_run;

  assign m_dout         = fir_dout;
  assign m_dout_valid   = fir_dout_valid;
  assign fir_dout_ready = m_dout_ready;

  assign w_in_hs  = s_din_valid & fir_din_ready & w_run;
  assign w_out_hs = fir_dout_valid & m_dout_ready;
  assign w_tap_hs = w_tap_valid & fir_tap_din_ready;

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_UNLOADED;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_fir_enable = state_fir_enabled(r_state);
    w_busy       = state_is_busy(r_state);
    w_tap_valid  = 1'b0;
    unique case (r_state)
      S_UNLOADED:   if (cfg_apply) w_next = S_DISABLE;
      S_RUN:        if (cfg_apply) w_next = S_DRAIN;
      // Registered count: a sample accepted in the apply cycle is already
      // counted here, and the last output handshake is seen one cycle later.
      S_DRAIN:      if (r_inflight == 2'd0) w_next = S_DISABLE;
      S_DISABLE:    w_next = S_WAIT_READY;
      S_WAIT_READY: if (fir_tap_din_ready) w_next = S_LOAD;
      S_LOAD: begin
        w_tap_valid = 1'b1;
        if (fir_tap_din_ready && (r_tap_idx == LP_LAST_TAP)) w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE:  if (fir_tap_din_done) w_next = S_RUN;
      default:      w_next = S_UNLOADED;
    endcase
  end

  assign fir_enable        = w_fir_enable;
  assign cfg_busy          = w_busy;
  assign fir_tap_din_valid = w_tap_valid;
  assign fir_tap_din       = w_tap_data;
  assign cfg_loaded        = r_loaded;
  assign dbg_state         = r_state;

  // ---------------------------------------------------------------------------
  // Counters and loaded flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tap_idx <= '0;
    end else if (r_state == S_DISABLE) begin
      // DISABLE always exits to WAIT_READY, so this is the entry clear.
      r_tap_idx <= '0;
    end else if (w_tap_hs) begin
      r_tap_idx <= r_tap_idx + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= 2'd0;
    end else begin
      unique case ({w_in_hs, w_out_hs})
        2'b10:   if (r_inflight != 2'd3) r_inflight <= r_inflight + 2'd1;
        2'b01:   if (r_inflight != 2'd0) r_inflight <= r_inflight - 2'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_loaded <= 1'b0;
    end else if ((w_next == S_RUN) && (r_state != S_RUN)) begin
      r_loaded <= 1'b1;
    end else if (w_next == S_DISABLE) begin
      r_loaded <= 1'b0;
    end
  end

  // An output with nothing in flight means the FIR and this block disagree.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(w_out_hs && !w_in_hs && (r_inflight == 2'd0)));
    end
  end

endmodule

// File: tb/tb_tiny_fir_ctrl.sv
module tb_tiny_fir_ctrl;
  import tiny_fir_ctrl_pkg::*;

  localparam int NT = 16;
  localparam int DW = 16;
  localparam int TW = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]    cfg_wr_addr = '0;
  logic [TW-1:0] cfg_wr_data = '0;
  logic          cfg_wr_en = 1'b0;
  logic          cfg_apply = 1'b0;
  logic          cfg_busy, cfg_loaded;
  logic [DW-1:0] s_din = '0;
  logic          s_din_valid = 1'b0;
  logic          s_din_ready;
  logic [DW-1:0] fir_din;
  logic          fir_din_valid, fir_din_ready;
  logic [DW-1:0] fir_dout;
  logic          fir_dout_valid, fir_dout_ready;
  logic [DW-1:0] m_dout;
  logic          m_dout_valid;
  logic          m_dout_ready = 1'b1;
  logic          fir_enable;
  logic [TW-1:0] fir_tap_din;
  logic          fir_tap_din_valid, fir_tap_din_ready, fir_tap_din_done;
  state_t        dbg_state;

  tiny_fir_ctrl #(.G_NUM_TAPS(NT), .G_DATA_WIDTH(DW), .G_TAP_WIDTH(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .cfg_wr_en(cfg_wr_en),
    .cfg_apply(cfg_apply), .cfg_busy(cfg_busy), .cfg_loaded(cfg_loaded),
    .s_din(s_din), .s_din_valid(s_din_valid), .s_din_ready(s_din_ready),
    .fir_din(fir_din), .fir_din_valid(fir_din_valid), .fir_din_ready(fir_din_ready),
    .fir_dout(fir_dout), .fir_dout_valid(fir_dout_valid), .fir_dout_ready(fir_dout_ready),
    .m_dout(m_dout), .m_dout_valid(m_dout_valid), .m_dout_ready(m_dout_ready),
    .fir_enable(fir_enable),
    .fir_tap_din(fir_tap_din), .fir_tap_din_valid(fir_tap_din_valid),
    .fir_tap_din_ready(fir_tap_din_ready), .fir_tap_din_done(fir_tap_din_done),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Behavioural FIR: taps streamed in order, 2-entry output buffer,
  // y = sum(tap[k]*x[n-k]) >> 15, flushed whenever fir_enable is low.
  // ---------------------------------------------------------------------------
  int            tap_mode = 0;   // 0: ready high, 1: toggle, 2: ready low
  logic          tap_rdy_r = 1'b0;
  logic [TW-1:0] m_taps [NT];
  logic [DW-1:0] m_hist [NT];
  int            m_tap_cnt;
  logic [DW-1:0] fq0, fq1, nx0, nx1;
  int            fq_cnt, nc;

  always @(posedge clk) begin
    case (tap_mode)
      0:       tap_rdy_r <= 1'b1;
      1:       tap_rdy_r <= ~tap_rdy_r;
      default: tap_rdy_r <= 1'b0;
    endcase
  end

  assign fir_tap_din_ready = fir_enable & tap_rdy_r;
  assign fir_tap_din_done  = (m_tap_cnt == NT);
  assign fir_din_ready     = fir_enable & fir_tap_din_done & (fq_cnt < 2);
  assign fir_dout_valid    = (fq_cnt != 0);
  assign fir_dout          = fq0;

  function automatic logic [DW-1:0] fir_calc(input logic [DW-1:0] x);
    logic [47:0] acc;
    acc = 48'(m_taps[0]) * 48'(x);
    for (int k = 1; k < NT; k++) acc = acc + 48'(m_taps[k]) * 48'(m_hist[k-1]);
    return acc[30:15];
  endfunction

  always_comb begin
    nx0 = fq0;
    nx1 = fq1;
    nc  = fq_cnt;
    if (fir_dout_valid && fir_dout_ready) begin
      nx0 = fq1;
      nc  = nc - 1;
    end
    if (fir_din_valid && fir_din_ready) begin
      if (nc == 0) nx0 = fir_calc(fir_din);
      else         nx1 = fir_calc(fir_din);
      nc = nc + 1;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || !fir_enable) begin
      m_tap_cnt <= 0;
      fq_cnt    <= 0;
      fq0       <= '0;
      fq1       <= '0;
      for (int k = 0; k < NT; k++) begin
        m_taps[k] <= '0;
        m_hist[k] <= '0;
      end
    end else begin
      if (fir_tap_din_valid && fir_tap_din_ready && (m_tap_cnt < NT)) begin
        m_taps[m_tap_cnt[3:0]] <= fir_tap_din;
        m_tap_cnt <= m_tap_cnt + 1;
      end
      if (fir_din_valid && fir_din_ready) begin
        m_hist[0] <= fir_din;
        for (int k = 1; k < NT; k++) m_hist[k] <= m_hist[k-1];
      end
      fq0    <= nx0;
      fq1    <= nx1;
      fq_cnt <= nc;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            tap_hs_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [TW-1:0] tap_exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (fir_tap_din_valid) begin
        check_val("tap_exp_avail", 32'(tap_exp_q.size() != 0), 32'd1);
        if (tap_exp_q.size() != 0) begin
          check_val("tap_din", 32'(fir_tap_din), 32'(tap_exp_q[0]));
          if (fir_tap_din_ready) begin
            void'(tap_exp_q.pop_front());
            tap_hs_cnt++;
          end
        end
      end
      if (m_dout_valid && m_dout_ready) begin
        check_val("out_exp_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_val("m_dout", 32'(m_dout), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_shadow(input int addr, input logic [TW-1:0] data);
    cfg_wr_addr = 4'(addr);
    cfg_wr_data = data;
    cfg_wr_en   = 1'b1;
    tick(1);
    cfg_wr_en   = 1'b0;
  endtask

  task automatic pulse_apply();
    cfg_apply = 1'b1;
    tick(1);
    cfg_apply = 1'b0;
  endtask

  task automatic load_exp_taps(input logic [TW-1:0] t0, input logic [TW-1:0] t1);
    tap_exp_q.delete();
    tap_exp_q.push_back(t0);
    tap_exp_q.push_back(t1);
    for (int i = 2; i < NT; i++) tap_exp_q.push_back('0);
    tap_hs_cnt = 0;
  endtask

  task automatic send_sample(input logic [DW-1:0] x, input logic [DW-1:0] y);
    bit ok;
    bit rdy;
    ok = 1'b0;
    exp_q.push_back(y);
    s_din = x;
    s_din_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = s_din_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    s_din_valid = 1'b0;
    check_val("s_din_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_state(input state_t s, input int budget, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dbg_state == s) begin
        hit = 1'b1;
        break;
      end
      tick(1);
    end
    check_val(tag, 32'(hit), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check_val("out_drained", 32'(ok), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    tick(3);
    check_val("rst_state", 32'(dbg_state), 32'(S_UNLOADED));
    check_val("rst_enable", 32'(fir_enable), 32'd0);
    check_val("rst_busy", 32'(cfg_busy), 32'd0);
    check_val("rst_loaded", 32'(cfg_loaded), 32'd0);
    check_val("rst_tap_valid", 32'(fir_tap_din_valid), 32'd0);
    reset_n = 1'b1;
    tick(2);
    check_val("unl_s_din_ready", 32'(s_din_ready), 32'd0);

    // Basic load: tap0=0x7FFF, 0x1000 -> 0x0FFF
    wr_shadow(0, 16'h7FFF);
    for (int i = 1; i < NT; i++) wr_shadow(i, 16'h0000);
    load_exp_taps(16'h7FFF, 16'h0000);
    pulse_apply();
    check_val("apply_disable", 32'(dbg_state), 32'(S_DISABLE));
    check_val("disable_enable", 32'(fir_enable), 32'd0);
    check_val("disable_busy", 32'(cfg_busy), 32'd1);
    tick(1);
    check_val("wait_ready_enable", 32'(fir_enable), 32'd1);
    wait_state(S_RUN, 60, "load1_run");
    check_val("load1_hs", 32'(tap_hs_cnt), 32'd16);
    check_val("load1_loaded", 32'(cfg_loaded), 32'd1);
    check_val("load1_busy", 32'(cfg_busy), 32'd0);
    check_val("run_s_din_ready", 32'(s_din_ready), 32'd1);
    send_sample(16'h1000, 16'h0FFF);
    wait_drain(20);

    // Drain with output stalled, toggling tap ready during reload
    m_dout_ready = 1'b0;
    send_sample(16'h2000, 16'h1FFF);
    tick(5);
    check_val("stall_out_valid", 32'(m_dout_valid), 32'd1);
    check_val("stall_in_ready", 32'(s_din_ready), 32'd1);
    tap_mode = 1;
    load_exp_taps(16'h7FFF, 16'h0000);
    pulse_apply();
    s_din = 16'h5555;
    s_din_valid = 1'b1;
    #1;
    check_val("drain_state", 32'(dbg_state), 32'(S_DRAIN));
    check_val("drain_s_din_ready", 32'(s_din_ready), 32'd0);
    check_val("drain_fir_din_valid", 32'(fir_din_valid), 32'd0);
    check_val("drain_loaded", 32'(cfg_loaded), 32'd1);
    check_val("drain_enable", 32'(fir_enable), 32'd1);
    tick(2);
    check_val("drain_hold", 32'(dbg_state), 32'(S_DRAIN));
    s_din_valid = 1'b0;
    m_dout_ready = 1'b1;
    tick(1);
    check_val("en_after_hs", 32'(fir_enable), 32'd1);
    tick(1);
    check_val("en_drop", 32'(fir_enable), 32'd0);
    check_val("loaded_drop", 32'(cfg_loaded), 32'd0);
    tick(1);
    check_val("en_back", 32'(fir_enable), 32'd1);
    wait_state(S_RUN, 80, "load2_run");
    check_val("load2_hs", 32'(tap_hs_cnt), 32'd16);
    send_sample(16'h0100, 16'h00FF);
    wait_drain(20);

    // Writes and apply while busy are ignored
    tap_mode = 2;
    load_exp_taps(16'h7FFF, 16'h0000);
    pulse_apply();
    wait_state(S_WAIT_READY, 5, "busy_wait_ready");
    wr_shadow(3, 16'h1234);
    pulse_apply();
    tick(2);
    check_val("busy_no_restart", 32'(dbg_state), 32'(S_WAIT_READY));
    check_val("busy_flag", 32'(cfg_busy), 32'd1);
    tap_mode = 1;
    wait_state(S_LOAD, 10, "busy_load");
    tick(2);
    pulse_apply();
    wait_state(S_RUN, 80, "load3_run");
    check_val("load3_hs", 32'(tap_hs_cnt), 32'd16);
    check_val("load3_taps_left", 32'(tap_exp_q.size()), 32'd0);

    // New coefficients: two-tap average
    tap_mode = 0;
    wr_shadow(0, 16'h4000);
    wr_shadow(1, 16'h4000);
    load_exp_taps(16'h4000, 16'h4000);
    pulse_apply();
    wait_state(S_RUN, 60, "load4_run");
    check_val("load4_hs", 32'(tap_hs_cnt), 32'd16);
    send_sample(16'h1000, 16'h0800);
    send_sample(16'h2000, 16'h1800);
    wait_drain(20);

    // Reset during LOAD
    tap_mode = 1;
    load_exp_taps(16'h4000, 16'h4000);
    pulse_apply();
    wait_state(S_LOAD, 20, "rst_mid_load");
    tick(3);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_enable", 32'(fir_enable), 32'd0);
    check_val("async_busy", 32'(cfg_busy), 32'd0);
    check_val("async_loaded", 32'(cfg_loaded), 32'd0);
    check_val("async_tap_valid", 32'(fir_tap_din_valid), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check_val("post_rst_state", 32'(dbg_state), 32'(S_UNLOADED));
    load_exp_taps(16'h4000, 16'h4000);
    pulse_apply();
    check_val("restart_disable", 32'(dbg_state), 32'(S_DISABLE));
    wait_state(S_RUN, 80, "load5_run");
    check_val("load5_hs", 32'(tap_hs_cnt), 32'd16);
    check_val("load5_loaded", 32'(cfg_loaded), 32'd1);
    send_sample(16'h1000, 16'h0800);
    wait_drain(20);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
